cpu_control: RTL and testbench
==============================

// Module: cpu_control
// PURPOSE
//  Multi-cycle fetch/decode/sequencing controller for the 6-bit ISA.
//  Fetches 12-bit instructions, splits them into op/RA/RB/RD and reads the register file.
//  Drives the ALU with those operands and consumes its single result alu_d.
//  That result is steered into a register write or the next PC.
//  Sits between instruction memory and the ALU; owns PC, IR, register file and halt state.
// PARAMETERS
//  DATA_W     6  datapath/PC width; fixed at 2*IDX_W (LDI/JMP pack {RA,RB})
//  IDX_W      3  register index and instruction-field width; 2**IDX_W registers
//  CNT_W      8  width of retired-instruction counter
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       async active-low reset
//  start       in   1       level; begin/restart execution from PC 0
//  imem_addr   out  DATA_W  instruction address (= PC)
//  imem_rdata  in   12      instruction word, valid 1 cycle after imem_addr
//  alu_op      out  3       opcode to ALU
//  alu_ra      out  IDX_W   RA field to ALU
//  alu_rb      out  IDX_W   RB field to ALU
//  alu_rd      out  IDX_W   RD field to ALU
//  alu_a       out  DATA_W  R[RA]
//  alu_b       out  DATA_W  R[RB]
//  alu_pc      out  DATA_W  current PC
//  alu_d       in   DATA_W  ALU result (combinational from the above)
//  pc          out  DATA_W  architectural PC
//  halted      out  1       1 in HALTED state
//  busy        out  1       1 in FETCH/DECODE/EXEC
//  retired     out  CNT_W   instructions retired, saturating
//  dbg_sel     in   IDX_W   debug register select
//  dbg_data    out  DATA_W  R[dbg_sel], combinational read
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, PC=0, IR=0, retired=0, all registers=0.
//   halted=0, busy=0; ALU outputs are 0 (decode of IR=0).
//  Instruction word: op=[11:9] RA=[8:6] RB=[5:3] RD=[2:0].
//  Opcodes: 0 HALT, 1 LDI, 2 ADD, 3 ADI, 4 MUL, 5 CMPJ, 6 JMP, 7 NOP.
//  FSM:
//   IDLE -(start)-> FETCH.
//   FETCH -> DECODE: imem_addr=PC.
//   DECODE -> EXEC: IR<=imem_rdata.
//   EXEC -> FETCH, or EXEC -> HALTED on op 0.
//   HALTED -(start)-> FETCH with PC<=0; registers and retired are kept.
//  Latency: exactly 3 cycles per instruction; state effects land on the EXEC->next edge.
//  EXEC commits, all widths mod 2**DATA_W:
//   LDI/ADD/ADI/MUL: R[RD]<=alu_d; PC<=PC+1.
//   CMPJ/JMP: PC<=alu_d; no register write.
//   NOP: PC<=PC+1.
//   HALT: PC unchanged; no write.
//  retired increments on every EXEC, HALT included, and saturates at all-ones.
//  ALU outputs are driven from IR every cycle; alu_d is used only in EXEC.
//  Register reads are combinational, so RD==RA or RD==RB reads the old value in EXEC.
//  PC wraps 63->0 on +1 and on CMPJ offset add. No fault is raised.
//  start is ignored in FETCH/DECODE/EXEC.
//  rst_n mid-EXEC: no commit occurs; everything returns to reset values.
// STRUCTURE
//  cpu_pkg: opcode_t enum (HALT..NOP), state_t enum, instr_t packed struct {op,ra,rb,rd},
//   and the DATA_W/IDX_W constants.
//  One sub-module: cpu_reg_file.
//   2**IDX_W x DATA_W with 2 async read ports, 1 debug read port and 1 sync write port.
//   Async active-low clear.
//  The ALU is instantiated by the parent, not inside cpu_control.
// TESTING
//  LDI R1,#05; LDI R2,#07; ADD R3=R1+R2; HALT -> R3=12, halted=1, retired=4, pc=3.
//  LDI R1,#9; MUL R2=R1*R1 -> R2=81 mod 64=17; ADI R2,R2,#7 -> R2=24.
//  CMPJ R1>=R2 RD=3 at PC=4:
//   taken (R1=9, R2=9) -> PC=7.
//   not taken (R1=1, R2=2) -> PC=5.
//  JMP #3F at PC 10 -> PC=63; NOP at 63 -> PC=0 (wrap); start in IDLE vs busy ignored.
//  rst_n low during EXEC of ADD R3 -> R3 stays 0, PC=0, state IDLE, retired=0.
//  After HALT, assert start -> PC=0, FETCH next cycle, registers retained; dbg_sel=3 shows R3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 6-bit multi-cycle controller.
//   opcode_t : 3-bit opcode, HALT..NOP
//   state_t  : sequencing FSM states
//   instr_t  : 12-bit instruction word {op, ra, rb, rd}
//   IDX_W / DATA_W / CNT_W : field, datapath and retire-counter widths
package cpu_pkg;

  localparam int IDX_W   = 3;
  // LDI and JMP build a full datapath value from {RA,RB}, so the datapath
  // is exactly two fields wide.
  localparam int DATA_W  = 2 * IDX_W;
  localparam int CNT_W   = 8;
  localparam int INSTR_W = 3 + 3 * IDX_W;

  typedef enum logic [2:0] {
    OP_HALT = 3'd0,
    OP_LDI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_ADI  = 3'd3,
    OP_MUL  = 3'd4,
    OP_CMPJ = 3'd5,
    OP_JMP  = 3'd6,
    OP_NOP  = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  typedef struct packed {
    opcode_t          op;
    logic [IDX_W-1:0] ra;
    logic [IDX_W-1:0] rb;
    logic [IDX_W-1:0] rd;
  } instr_t;

endpackage

// File: rtl/cpu_reg_file.sv
// General-purpose register file: 2**IDX_W entries of DATA_W bits.
//   clk, rst_n          : clock, async active-low clear of every entry
//   ra_idx / ra_data    : async read port A
//   rb_idx / rb_data    : async read port B
//   dbg_idx / dbg_data  : async debug read port
//   wr_en/wr_idx/wr_data: synchronous write port
module cpu_reg_file #(
  parameter int DATA_W = 6,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  ra_idx,
  input  logic [IDX_W-1:0]  rb_idx,
  input  logic [IDX_W-1:0]  dbg_idx,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 2 ** IDX_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see the pre-write contents, so RD==RA/RB uses the old value.
  assign ra_data  = regs_q[ra_idx];
  assign rb_data  = regs_q[rb_idx];
  assign dbg_data = regs_q[dbg_idx];

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle fetch/decode/execute sequencer for the 6-bit ISA.
// Owns PC, IR, register file, retire counter and halt state; the ALU sits
// outside and returns a single combinational result on alu_d.
//   start                  : level, begins execution from IDLE or HALTED
//   imem_addr / imem_rdata : instruction fetch (data one cycle after address)
//   alu_op/ra/rb/rd/a/b/pc : decoded IR, operands and PC presented to the ALU
//   alu_d                  : ALU result, committed only in EXEC
//   pc, halted, busy       : architectural status
//   retired                : saturating count of executed instructions
//   dbg_sel / dbg_data     : combinational register peek
module cpu_control
  import cpu_pkg::*;
#(
  parameter int IDX_W  = cpu_pkg::IDX_W,
  parameter int DATA_W = 2 * IDX_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [11:0]       imem_rdata,
  output logic [2:0]        alu_op,
  output logic [IDX_W-1:0]  alu_ra,
  output logic [IDX_W-1:0]  alu_rb,
  output logic [IDX_W-1:0]  alu_rd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_pc,
  input  logic [DATA_W-1:0] alu_d,
  output logic [DATA_W-1:0] pc,
  output logic              halted,
  output logic              busy,
  output logic [CNT_W-1:0]  retired,
  input  logic [IDX_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  instr_t            ir_q, ir_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              wr_en;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = (ir_q.op == OP_HALT) ? ST_HALTED : ST_FETCH;
      ST_HALTED: if (start) state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    halted = (state_q == ST_HALTED);
    busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
             (state_q == ST_EXEC);
  end

  // PC / IR / retire counter updates and register write enable
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    wr_en     = 1'b0;
    if (state_q == ST_DECODE) ir_d = instr_t'(imem_rdata);
    if (state_q == ST_HALTED && start) pc_d = '0;
    if (state_q == ST_EXEC) begin
      if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + 1'b1;
      case (ir_q.op)
        OP_LDI, OP_ADD, OP_ADI, OP_MUL: begin
          wr_en = 1'b1;
          pc_d  = pc_q + 1'b1;
        end
        // Branch targets (including the CMPJ not-taken PC+1) come from the ALU.
        OP_CMPJ, OP_JMP: pc_d = alu_d;
        OP_NOP:          pc_d = pc_q + 1'b1;
        default:         pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= '0;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  cpu_reg_file #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_idx   (ir_q.ra),
    .rb_idx   (ir_q.rb),
    .dbg_idx  (dbg_sel),
    .wr_en    (wr_en),
    .wr_idx   (ir_q.rd),
    .wr_data  (alu_d),
    .ra_data  (alu_a),
    .rb_data  (alu_b),
    .dbg_data (dbg_data)
  );

  // The ALU always sees the held IR, so its inputs are stable across a whole instruction.
  assign alu_op    = ir_q.op;
  assign alu_ra    = ir_q.ra;
  assign alu_rb    = ir_q.rb;
  assign alu_rd    = ir_q.rd;
  assign alu_pc    = pc_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_cpu_control.sv
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  imem_addr;
  logic [11:0] imem_rdata;
  logic [2:0]  alu_op, alu_ra, alu_rb, alu_rd;
  logic [5:0]  alu_a, alu_b, alu_pc, alu_d, pc, dbg_data;
  logic        halted, busy;
  logic [7:0]  retired;
  logic [2:0]  dbg_sel, mon_sel, stim_sel;
  logic        mon_en = 1'b0;

  assign dbg_sel = mon_en ? mon_sel : stim_sel;

  cpu_control dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .alu_op(alu_op), .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_rd(alu_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_pc(alu_pc), .alu_d(alu_d),
    .pc(pc), .halted(halted), .busy(busy), .retired(retired),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Instruction memory: read data valid one cycle after the address.
  logic [11:0] prog [64];
  always @(posedge clk) imem_rdata <= prog[imem_addr];

  // Environment ALU.
  always_comb begin
    alu_d = '0;
    case (alu_op)
      3'd1, 3'd6: alu_d = {alu_ra, alu_rb};
      3'd2:       alu_d = alu_a + alu_b;
      3'd3:       alu_d = alu_a + {3'b000, alu_rb};
      3'd4:       alu_d = alu_a * alu_b;
      3'd5:       alu_d = (alu_a >= alu_b) ? alu_pc + {3'b000, alu_rd} : alu_pc + 6'd1;
      default:    alu_d = '0;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- ISA-level reference model ----------------
  typedef struct {
    logic [11:0] instr;
    int a, b, pc0, pc1, rd, rdval, ret;
    bit halt;
  } exp_t;

  exp_t q[$];
  int   m_reg [8];
  int   m_pc, m_ret;
  bit   m_halt;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_reg[i] = 0;
    m_pc = 0; m_ret = 0; m_halt = 1'b0;
  endtask

  task automatic model_step();
    exp_t e;
    logic [11:0] w;
    int op, ra, rb, rd, a, b;
    w  = prog[m_pc];
    op = int'(w[11:9]); ra = int'(w[8:6]); rb = int'(w[5:3]); rd = int'(w[2:0]);
    a  = m_reg[ra]; b = m_reg[rb];
    e.instr = w; e.a = a; e.b = b; e.pc0 = m_pc;
    case (op)
      0: m_halt = 1'b1;
      1: begin m_reg[rd] = ra * 8 + rb;   m_pc = (m_pc + 1) % 64; end
      2: begin m_reg[rd] = (a + b) % 64;  m_pc = (m_pc + 1) % 64; end
      3: begin m_reg[rd] = (a + rb) % 64; m_pc = (m_pc + 1) % 64; end
      4: begin m_reg[rd] = (a * b) % 64;  m_pc = (m_pc + 1) % 64; end
      5: m_pc = (a >= b) ? (m_pc + rd) % 64 : (m_pc + 1) % 64;
      6: m_pc = ra * 8 + rb;
      default: m_pc = (m_pc + 1) % 64;
    endcase
    m_ret = (m_ret < 255) ? m_ret + 1 : 255;
    e.pc1 = m_pc; e.rd = rd; e.rdval = m_reg[rd]; e.ret = m_ret; e.halt = m_halt;
    q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  // A running instruction occupies three busy cycles; the third is EXEC,
  // and its effects are visible one cycle later.
  initial begin
    int   ph;
    bit   pend;
    exp_t cur;
    ph = 0; pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        ph = 0; pend = 1'b0;
      end else begin
        if (pend) begin
          mon_sel = 3'(cur.rd);
          #1;
          check("commit_pc", int'(pc), cur.pc1);
          check("commit_halted", int'(halted), int'(cur.halt));
          check("commit_retired", int'(retired), cur.ret);
          check("commit_reg", int'(dbg_data), cur.rdval);
          pend = 1'b0;
          n_done++;
        end
        if (busy) begin
          ph++;
          if (ph == 3) begin
            ph = 0;
            if (q.size() == 0) begin
              check("unexpected_retire", 1, 0);
            end else begin
              cur = q.pop_front();
              check("exec_instr", int'({alu_op, alu_ra, alu_rb, alu_rd}), int'(cur.instr));
              check("exec_alu_a", int'(alu_a), cur.a);
              check("exec_alu_b", int'(alu_b), cur.b);
              check("exec_alu_pc", int'(alu_pc), cur.pc0);
              pend = 1'b1;
            end
          end
        end else begin
          ph = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [11:0] enc(int op, int ra, int rb, int rd);
    return 12'((op << 9) | (ra << 6) | (rb << 3) | rd);
  endfunction

  function automatic logic [11:0] ldi(int rd, int imm);
    return enc(1, imm >> 3, imm & 7, rd);
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = enc(7, 0, 0, 0);
  endtask

  task automatic peek(input int idx, output int val);
    mon_en = 1'b0;
    stim_sel = 3'(idx);
    #1;
    val = int'(dbg_data);
    mon_en = 1'b1;
  endtask

  task automatic do_reset();
    int nz;
    #2;
    mon_en = 1'b0; rst_n = 1'b0; start = 1'b0;
    #1;
    check("rst_pc", int'(pc), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_retired", int'(retired), 0);
    check("rst_alu_fields", int'({alu_op, alu_ra, alu_rb, alu_rd}), 0);
    check("rst_alu_ab", int'({alu_a, alu_b}), 0);
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      stim_sel = 3'(i);
      #1;
      if (dbg_data != 6'd0) nz++;
    end
    check("rst_regs_nonzero", nz, 0);
    q.delete();
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  // Called at a negedge with the DUT in IDLE or HALTED.
  task automatic run_prog(input int cap, input bit hold, output bit halted_o);
    int n, target;
    bit done;
    n = 0; done = 1'b0;
    m_pc = 0; m_halt = 1'b0;
    while (!m_halt && n < cap) begin
      model_step();
      n++;
    end
    target = n_done + n;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    #1;
    check("start_fetch", int'({busy, halted, pc}), int'({1'b1, 1'b0, 6'd0}));
    for (int c = 0; c < n * 3 + 20; c++) begin
      if (n_done >= target) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("run_completed", int'(done), 1);
    start = 1'b0;
    halted_o = m_halt && done;
    if (!done) do_reset();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit h;
    int v;
    stim_sel = '0; mon_sel = '0;
    clear_prog();
    model_clear();
    @(negedge clk);
    do_reset();

    // LDI/LDI/ADD/HALT
    clear_prog();
    prog[0] = ldi(1, 5); prog[1] = ldi(2, 7); prog[2] = enc(2, 1, 2, 3); prog[3] = enc(0, 0, 0, 0);
    run_prog(20, 1'b0, h);
    peek(3, v);
    check("p1_r3", v, 12);
    check("p1_halted", int'(halted), 1);
    check("p1_retired", int'(retired), 4);
    check("p1_pc", int'(pc), 3);

    // Restart from HALTED: LDI/MUL/ADI/HALT, R3 retained
    clear_prog();
    prog[0] = ldi(1, 9); prog[1] = enc(4, 1, 1, 2); prog[2] = enc(3, 2, 7, 2); prog[3] = enc(0, 0, 0, 0);
    run_prog(20, 1'b0, h);
    peek(2, v);
    check("p2_r2", v, 24);
    peek(3, v);
    check("p2_r3_retained", v, 12);
    check("p2_retired", int'(retired), 8);

    // CMPJ taken at PC 4
    clear_prog();
    prog[0] = ldi(1, 9); prog[1] = ldi(2, 9); prog[4] = enc(5, 1, 2, 3);
    prog[5] = enc(0, 0, 0, 0); prog[7] = enc(0, 0, 0, 0);
    run_prog(20, 1'b0, h);
    check("cmpj_taken_pc", int'(pc), 7);

    // CMPJ not taken at PC 4
    prog[0] = ldi(1, 1); prog[1] = ldi(2, 2);
    run_prog(20, 1'b0, h);
    check("cmpj_not_taken_pc", int'(pc), 5);

    // JMP 10, JMP 63, NOP wraps to 0; start held high throughout
    do_reset();
    clear_prog();
    prog[0] = enc(6, 1, 2, 0); prog[10] = enc(6, 7, 7, 0);
    run_prog(3, 1'b1, h);
    check("jmp_wrap_pc", int'(pc), 0);
    check("jmp_wrap_retired", int'(retired), 3);
    do_reset();

    // Reset during EXEC of ADD R3
    mon_en = 1'b0;
    clear_prog();
    prog[0] = ldi(1, 5); prog[1] = ldi(2, 7); prog[2] = enc(2, 1, 2, 3); prog[3] = enc(0, 0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("midexec_alu_op", int'(alu_op), 2);
    check("midexec_alu_ab", int'({alu_a, alu_b}), int'({6'd5, 6'd7}));
    do_reset();

    // Retire counter saturation on an endless NOP loop
    clear_prog();
    run_prog(300, 1'b0, h);
    check("retired_saturated", int'(retired), 255);
    do_reset();

    // Random programs
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 64; i++) prog[i] = 12'($urandom_range(0, 4095));
      run_prog(40, 1'b0, h);
      if (!h) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
